// File: rtl/axi_pkg.sv
// axi_pkg: shared types and constants for the AXI write arbiter.
// Holds the FSM state enum, master count, default output delay and a one-hot to index helper.
package axi_pkg;
  typedef enum logic [1:0] {IDLE, AW, W, B} state_t;
  localparam int NUM_M   = 4;
  localparam int TCO_DEF = 1;
  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction
endpackage

// File: rtl/axi_rr_pick.sv
// axi_rr_pick: combinational round-robin picker.
// Ports: req (request vector), ptr (highest-priority index), gnt (one-hot winner), valid (any request).
module axi_rr_pick
  import axi_pkg::*;
(
  input  logic [NUM_M-1:0] req,
  input  logic [1:0]       ptr,
  output logic [NUM_M-1:0] gnt,
  output logic             valid
);
  // Walk from the farthest offset down so the requester closest to ptr is written last and wins.
  always_comb begin
    gnt = '0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) begin
        gnt = '0;
        gnt[ptr + 2'(i)] = 1'b1;
      end
    end
  end
  assign valid = |req;
endmodule

// File: rtl/axi_write_arbiter.sv
// axi_write_arbiter: four-master round-robin AXI write-channel arbiter with burst checking and stall watchdog.
// Inputs: ACLK, ARESETn, m0..m3_AWVALID, s_AWREADY, m_AWLEN, m_WVALID, m_WLAST, m_BREADY, s_WREADY, s_BVALID.
// Outputs (all registered): m0..m3_wgrnt (one-hot grant), busy, err_wlast (pulse), timeout (pulse).
module axi_write_arbiter
  import axi_pkg::*;
#(
  parameter int TCO         = TCO_DEF,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic       ACLK,
  input  logic       ARESETn,
  input  logic       m0_AWVALID,
  input  logic       m1_AWVALID,
  input  logic       m2_AWVALID,
  input  logic       m3_AWVALID,
  input  logic       s_AWREADY,
  input  logic [7:0] m_AWLEN,
  input  logic       m_WVALID,
  input  logic       m_WLAST,
  input  logic       m_BREADY,
  input  logic       s_WREADY,
  input  logic       s_BVALID,
  output logic       m0_wgrnt,
  output logic       m1_wgrnt,
  output logic       m2_wgrnt,
  output logic       m3_wgrnt,
  output logic       busy,
  output logic       err_wlast,
  output logic       timeout
);
  state_t      state_q, state_d;
  logic [3:0]  grant_q, grant_d, pick_gnt, awvalid;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        busy_q, busy_d, err_q, err_d, to_q, to_d;
  logic        pick_valid, aw_hs, w_hs, b_hs, hs, expire;
  logic        unused_tco;
  // TCO only models clock-to-out delay in simulation; synthesizable logic carries no delay.
  assign unused_tco = (TCO > 0);
  assign awvalid = {m3_AWVALID, m2_AWVALID, m1_AWVALID, m0_AWVALID};
  axi_rr_pick u_pick (
    .req  (awvalid),
    .ptr  (rr_ptr_q),
    .gnt  (pick_gnt),
    .valid(pick_valid)
  );
  assign aw_hs  = (state_q == AW) && |(grant_q & awvalid) && s_AWREADY;
  assign w_hs   = (state_q == W) && m_WVALID && s_WREADY;
  assign b_hs   = (state_q == B) && s_BVALID && m_BREADY;
  assign hs     = aw_hs || w_hs || b_hs;
  assign expire = (state_q != IDLE) && !hs && (stall_cnt_q == 16'(TIMEOUT_CYC - 1));
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = 1'b0;
    to_d       = 1'b0;
    case (state_q)
      IDLE: if (pick_valid) begin
        grant_d = pick_gnt;
        state_d = AW;
      end
      AW: if (aw_hs) begin
        beat_cnt_d = m_AWLEN;
        state_d    = W;
      end
      W: if (w_hs) begin
        // WLAST must be high exactly on the beat that finds the counter already at zero.
        err_d      = (beat_cnt_q == 8'd0) ? !m_WLAST : m_WLAST;
        beat_cnt_d = (beat_cnt_q == 8'd0) ? 8'd0 : beat_cnt_q - 8'd1;
        state_d    = (beat_cnt_q == 8'd0) ? B : W;
      end
      B: if (b_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (expire) begin
      state_d = IDLE;
      to_d    = 1'b1;
    end
    // Completion and abort both release the grant and move priority past the served master.
    if (state_q != IDLE && state_d == IDLE) begin
      grant_d  = '0;
      rr_ptr_d = oh2idx(grant_q) + 2'd1;
    end
    stall_cnt_d = (state_q == IDLE || state_d == IDLE || hs) ? 16'd0 : stall_cnt_q + 16'd1;
    busy_d      = (state_d != IDLE);
  end
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      to_q        <= to_d;
    end
  end
  assign {m3_wgrnt, m2_wgrnt, m1_wgrnt, m0_wgrnt} = grant_q;
  assign busy      = busy_q;
  assign err_wlast = err_q;
  assign timeout   = to_q;
endmodule

// File: tb/tb_axi_write_arbiter.sv
// tb_axi_write_arbiter: randomized scoreboard bench for axi_write_arbiter with a behavioural arbitration model.
module tb_axi_write_arbiter;
  logic       ACLK = 1'b0;
  logic       ARESETn = 1'b0;
  logic [3:0] awv = '0;
  logic       s_AWREADY = 1'b0;
  logic [7:0] m_AWLEN = '0;
  logic       m_WVALID = 1'b0, m_WLAST = 1'b0, m_BREADY = 1'b0, s_WREADY = 1'b0, s_BVALID = 1'b0;
  logic [3:0] gnt;
  logic       busy, err_wlast, timeout;
  int tests = 0, fails = 0;
  typedef struct {int errs; int tos;} end_t;
  int   exp_idx_q[$];
  end_t exp_end_q[$];
  logic [3:0] pending = '0;
  int ptr = 0;
  always #5 ACLK = ~ACLK;
  axi_write_arbiter #(.TIMEOUT_CYC(8)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .m0_AWVALID(awv[0]), .m1_AWVALID(awv[1]), .m2_AWVALID(awv[2]), .m3_AWVALID(awv[3]),
    .s_AWREADY(s_AWREADY), .m_AWLEN(m_AWLEN), .m_WVALID(m_WVALID), .m_WLAST(m_WLAST),
    .m_BREADY(m_BREADY), .s_WREADY(s_WREADY), .s_BVALID(s_BVALID),
    .m0_wgrnt(gnt[0]), .m1_wgrnt(gnt[1]), .m2_wgrnt(gnt[2]), .m3_wgrnt(gnt[3]),
    .busy(busy), .err_wlast(err_wlast), .timeout(timeout)
  );
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge ACLK);
    @(negedge ACLK);
  endtask
  // Winner is the first requester found scanning upward from the priority pointer, modulo 4.
  function automatic int rr_model(input logic [3:0] req, input int p);
    for (int i = 0; i < 4; i++) if (req[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction
  // Monitor: grant rise pops the expected winner, grant fall pops the expected pulse counts.
  logic [3:0] prev_g = '0;
  int errs_acc = 0, tos_acc = 0;
  always @(negedge ACLK) begin
    int e;
    end_t x;
    errs_acc += int'(err_wlast);
    tos_acc  += int'(timeout);
    if (prev_g == 0 && gnt != 0) begin
      if (exp_idx_q.size() == 0) chk("grant_unexpected", int'(gnt), 0);
      else begin
        e = exp_idx_q.pop_front();
        chk("grant_onehot", int'(gnt), 1 << e);
      end
    end
    if (prev_g != 0 && gnt == 0) begin
      if (exp_end_q.size() == 0) chk("end_unexpected", exp_end_q.size(), 1);
      else begin
        x = exp_end_q.pop_front();
        chk("err_wlast_count", errs_acc, x.errs);
        chk("timeout_count", tos_acc, x.tos);
      end
      errs_acc = 0;
      tos_acc  = 0;
    end
    prev_g = gnt;
  end
  // fmode: 0 random WLAST faults, 1 clean, 2 WLAST inverted on every beat.
  task automatic txn(input logic [3:0] add, input int len_in, input int fmode, input bit force_to, input bit do_rst);
    int w, len, errs, d, n;
    bit wl, to_mode;
    end_t x;
    pending |= add;
    if (pending == 0) pending[$urandom_range(0, 3)] = 1'b1;
    w = rr_model(pending, ptr);
    exp_idx_q.push_back(w);
    awv = pending;
    tick;
    chk("grant_latency", int'({busy, |gnt}), 3);
    pending[w] = 1'b0;
    len = (len_in < 0) ? int'($urandom_range(0, 7)) : len_in;
    m_AWLEN = len[7:0];
    d = $urandom_range(0, 3);
    repeat (d) begin
      awv = pending;
      s_AWREADY = 1'($urandom_range(0, 1));
      tick;
    end
    awv[w] = 1'b1;
    s_AWREADY = 1'b1;
    tick;
    awv = pending;
    s_AWREADY = 1'b0;
    m_AWLEN = 8'($urandom);
    errs = 0;
    for (int b = 0; b <= len; b++) begin
      if (do_rst && b == len / 2) begin
        x.errs = errs;
        x.tos = 0;
        exp_end_q.push_back(x);
        ARESETn = 1'b0;
        #1;
        chk("rst_grant", int'(gnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err_wlast), 0);
        chk("rst_timeout", int'(timeout), 0);
        awv = '0;
        m_WVALID = 1'b0;
        s_WREADY = 1'b0;
        m_WLAST = 1'b0;
        tick;
        tick;
        ARESETn = 1'b1;
        pending = '0;
        ptr = 0;
        return;
      end
      d = $urandom_range(0, 2);
      repeat (d) begin
        n = $urandom_range(0, 2);
        m_WVALID = (n == 1);
        s_WREADY = (n == 2);
        m_WLAST = 1'($urandom_range(0, 1));
        tick;
      end
      wl = (b == len);
      if (fmode == 2 || (fmode == 0 && $urandom_range(0, 7) == 0)) wl = !wl;
      errs += int'(wl != (b == len));
      m_WVALID = 1'b1;
      s_WREADY = 1'b1;
      m_WLAST = wl;
      tick;
      m_WVALID = 1'b0;
      s_WREADY = 1'b0;
      m_WLAST = 1'b0;
    end
    to_mode = force_to || (fmode == 0 && $urandom_range(0, 9) == 0);
    x.errs = errs;
    x.tos = int'(to_mode);
    exp_end_q.push_back(x);
    if (to_mode) begin
      n = 0;
      while (gnt != 0 && n < 20) begin
        s_BVALID = 1'b0;
        m_BREADY = 1'($urandom_range(0, 1));
        tick;
        n++;
      end
      chk("timeout_cycles", n, 8);
    end else begin
      d = $urandom_range(0, 3);
      repeat (d) begin
        n = $urandom_range(0, 2);
        s_BVALID = (n == 1);
        m_BREADY = (n == 2);
        tick;
      end
      s_BVALID = 1'b1;
      m_BREADY = 1'b1;
      tick;
      s_BVALID = 1'b0;
      m_BREADY = 1'b0;
      chk("idle_after_b", int'({busy, |gnt}), 0);
    end
    m_BREADY = 1'b0;
    ptr = (w + 1) % 4;
  endtask
  initial begin
    repeat (2) tick;
    chk("reset_grant", int'(gnt), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_err", int'(err_wlast), 0);
    chk("reset_timeout", int'(timeout), 0);
    ARESETn = 1'b1;
    tick;
    chk("idle_no_req", int'({busy, |gnt}), 0);
    txn(4'b0010, 3, 1, 1'b0, 1'b0);
    txn(4'b0000, 255, 1, 1'b0, 1'b0);
    txn(4'b0000, 1, 2, 1'b0, 1'b0);
    txn(4'($urandom_range(1, 15)), -1, 1, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) txn(4'($urandom_range(0, 15)), -1, 0, 1'b0, 1'b0);
    txn(4'($urandom_range(0, 15)), 6, 1, 1'b0, 1'b1);
    pending = 4'hF;
    for (int i = 0; i < 4; i++) txn(4'b0000, -1, 1, 1'b0, 1'b0);
    tick;
    tick;
    chk("queues_drained", exp_idx_q.size() + exp_end_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL global_watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/axi_write_arbiter.md
AXI_WRITE_ARBITER -- requirements
Module: axi_write_arbiter

Interface
REQ-001 SHALL have parameter TCO, default 1, register output delay in ns for simulation only.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024, stall cycles (range 2..65535) before the current transaction is aborted.
REQ-003 SHALL have port ACLK, input, 1, the single clock; every flop is clocked on the rising edge.
REQ-004 SHALL have port ARESETn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports m0_AWVALID..m3_AWVALID, input, 1 each, write-address requests of masters 0-3.
REQ-006 SHALL have port s_AWREADY, input, 1, slave address ready.
REQ-007 SHALL have port m_AWLEN, input, 8, AWLEN of the granted master, muxed externally.
REQ-008 SHALL have ports m_WVALID, m_WLAST and m_BREADY, input, 1 each, muxed signals of the granted master.
REQ-009 SHALL have ports s_WREADY and s_BVALID, input, 1 each, slave signals.
REQ-010 SHALL have ports m0_wgrnt..m3_wgrnt, output, 1 each, registered one-hot write grant.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-012 SHALL have port err_wlast, output, 1, one-cycle pulse on a WLAST or beat-count mismatch.
REQ-013 SHALL have port timeout, output, 1, one-cycle pulse when a transaction is aborted.

Function
REQ-014 SHALL implement states IDLE, AW, W and B in a registered FSM.
REQ-015 IDLE, no request: SHALL stay in IDLE with all grants low.
REQ-016 IDLE, any request: SHALL grant round-robin, searching from rr_ptr upward with wrap 3->0.
REQ-017 Grant latency: the grant SHALL be asserted the cycle after the request is seen in IDLE, with a simultaneous transition to AW.
REQ-018 The grant SHALL stay fixed through AW, W and B.
REQ-019 AW: on selected AWVALID and s_AWREADY, SHALL load beat_cnt (8 bits) = m_AWLEN and go to W.
- A deasserted AWVALID from the granted master SHALL be ignored, and the FSM stays in AW.
REQ-020 W beat: each m_WVALID and s_WREADY handshake with beat_cnt not 0 SHALL decrement beat_cnt.
- If m_WLAST=1 on such a beat, err_wlast SHALL pulse and the FSM stays in W.
REQ-021 W final beat: the handshake with beat_cnt=0 SHALL move the FSM to B.
- If m_WLAST=0 on that beat, err_wlast SHALL pulse.
REQ-022 AWLEN=255 SHALL produce exactly 256 beats, with no counter wrap.
REQ-023 B: on s_BVALID and m_BREADY, SHALL go to IDLE and drop the grant the next cycle, with rr_ptr = granted index + 1 mod 4.
REQ-024 A request present in the same cycle as the B handshake SHALL be arbitrated from IDLE on the following cycle, giving exactly one IDLE cycle between transactions.
REQ-025 Watchdog: a 16-bit stall_cnt SHALL count in AW, W and B, clear on any AW, W or B handshake, and clear on entry to IDLE.
REQ-026 Watchdog expiry: when stall_cnt = TIMEOUT_CYC-1 with no handshake in that cycle, timeout SHALL pulse and the FSM SHALL go to IDLE.
- On a timeout the grant SHALL drop and rr_ptr SHALL advance past the offender.
REQ-027 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-028 ARESETn low SHALL asynchronously force: state IDLE, all grants 0, busy 0, err_wlast 0, timeout 0, rr_ptr 0, beat_cnt 0, stall_cnt 0.
REQ-029 Reset asserted mid-transaction SHALL abandon the transaction without any error or timeout pulse.
REQ-030 After reset release, arbitration SHALL start from master 0.

Structure
REQ-031 The state enum, master count (4) and TCO default SHALL live in the shared package axi_pkg.
REQ-032 The round-robin picker SHALL be the combinational sub-module axi_rr_pick.
- Inputs: 4-bit request vector and 2-bit pointer.
- Outputs: 4-bit one-hot grant and a valid flag.
REQ-033 The FSM, counters and watchdog SHALL stay in axi_write_arbiter.

Verification
REQ-034 Reset, then m1_AWVALID=1 -> m1_wgrnt=1 and busy=1 one cycle later; AWLEN=3 with 4 beats, WLAST on beat 4, then B -> IDLE, rr_ptr=2, err_wlast never pulses.
REQ-035 m0..m3_AWVALID all held high for 4 transactions -> grant order 0,1,2,3, with one IDLE cycle between transactions.
REQ-036 AWLEN=255, 256 beats with WLAST on the last beat -> B entered after beat 256; beat_cnt never wraps.
REQ-037 AWLEN=1 with WLAST on beat 1 -> err_wlast pulses on beat 1; B entered after beat 2 with an err_wlast pulse (WLAST=0).
REQ-038 TIMEOUT_CYC=8, s_BVALID held 0 in B -> timeout pulses on the 8th stall cycle; grant drops; next requester granted.
REQ-039 ARESETn pulsed low mid W burst -> all outputs 0 immediately; no timeout or err_wlast pulse; master 0 wins first after release.
